// File: rtl/miss_record_reader_pkg.sv
// rtl/miss_record_reader_pkg.sv - record layout, end marker and state encoding for the miss record reader
package miss_record_reader_pkg;

    localparam int REC_W       = 28;
    localparam int FIELD_W     = 4;
    localparam int PILL_W      = 2 * FIELD_W;
    localparam int TAG_LSB     = 24;
    localparam int PILL0_LSB   = 16;
    localparam int PILL1_LSB   = 8;
    localparam int PILL2_LSB   = 0;
    localparam int MISS_OFFSET = 0;
    localparam int ID_OFFSET   = FIELD_W;

    localparam logic [FIELD_W-1:0] END_TAG   = 4'h0;
    localparam logic [1:0]         LAST_PILL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_LATCH,
        S_SHOW,
        S_NEXT,
        S_DONE
    } state_t;

    // Returns {id, misses} of the selected pill.
    function automatic logic [PILL_W-1:0] pill_field(input logic [REC_W-1:0] rec,
                                                     input logic [1:0]       pill);
        case (pill)
            2'd0:    pill_field = rec[PILL0_LSB +: PILL_W];
            2'd1:    pill_field = rec[PILL1_LSB +: PILL_W];
            default: pill_field = rec[PILL2_LSB +: PILL_W];
        endcase
    endfunction

endpackage

// File: rtl/miss_record_reader_dwell_timer.sv
// rtl/miss_record_reader_dwell_timer.sv - loadable down-counter that flags expiry at zero
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/miss_record_reader.sv
// rtl/miss_record_reader.sv - walks the miss log RAM and shows each pill entry; MISS_TOTAL_EN adds a saturating miss total
module miss_record_reader
    import miss_record_reader_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startReview,
    input  logic              stepNext,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramRdEn,
    input  logic [REC_W-1:0]  ramData,
    output logic [3:0]        displayTag,
    output logic [1:0]        displayPill,
    output logic [3:0]        displayId,
    output logic [3:0]        displayMisses,
    output logic              displayValid,
    output logic              busy,
    output logic              done
`ifdef MISS_TOTAL_EN
    ,
    output logic [7:0]        totalMisses
`endif
);

    localparam int                CNT_W      = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rd_en_q;
    logic [REC_W-1:0]   record_q;
    logic [1:0]         pill_q;

    logic expired;
    logic advance;
    logic timer_load;
    logic is_end;
    logic start_ok;

    assign is_end     = (ramData[TAG_LSB +: FIELD_W] == END_TAG);
    assign start_ok   = startReview && ((state_q == S_IDLE) || (state_q == S_DONE));
    // A coincident stepNext and expiry collapse into this single advance.
    assign advance    = (state_q == S_SHOW) && (expired || stepNext);
    assign timer_load = ((state_q == S_LATCH) && !is_end) || (advance && (pill_q != LAST_PILL));

    dwell_timer #(
        .W(CNT_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst_n      (resetN),
        .load_i     (timer_load),
        .load_val_i (DWELL_LOAD),
        .en_i       (state_q == S_SHOW),
        .expired_o  (expired)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            record_q <= '0;
            pill_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        addr_q  <= '0;
                        rd_en_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: state_q <= S_LATCH;
                S_LATCH: begin
                    record_q <= ramData;
                    pill_q   <= '0;
                    state_q  <= is_end ? S_DONE : S_SHOW;
                end
                S_SHOW: begin
                    if (advance) begin
                        if (pill_q != LAST_PILL) begin
                            pill_q <= pill_q + 2'd1;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        rd_en_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MISS_TOTAL_EN
    logic [7:0] total_q;
    logic [7:0] total_d;
    logic [8:0] total_sum;

    assign total_sum = 9'(total_q)
                     + 9'(ramData[PILL0_LSB + MISS_OFFSET +: FIELD_W])
                     + 9'(ramData[PILL1_LSB + MISS_OFFSET +: FIELD_W])
                     + 9'(ramData[PILL2_LSB + MISS_OFFSET +: FIELD_W]);
    assign total_d   = total_sum[8] ? 8'hFF : total_sum[7:0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            total_q <= '0;
        end else if (start_ok) begin
            total_q <= '0;
        end else if ((state_q == S_LATCH) && !is_end) begin
            total_q <= total_d;
        end
    end

    assign totalMisses = total_q;
`endif

    assign ramAddr      = addr_q;
    assign ramRdEn      = rd_en_q;
    assign displayTag   = record_q[TAG_LSB +: FIELD_W];
    assign displayPill  = pill_q;
    assign {displayId, displayMisses} = pill_field(record_q, pill_q);
    assign displayValid = (state_q == S_SHOW);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_miss_record_reader.sv
// tb/tb_miss_record_reader.sv - scoreboard bench for miss_record_reader with a RAM model and random stepping
module tb_miss_record_reader;

    localparam int AW   = 4;
    localparam int D    = 5;
    localparam int NREC = 1 << AW;

    typedef struct {
        logic [3:0] tag;
        logic [1:0] pill;
        logic [3:0] id;
        logic [3:0] misses;
    } entry_t;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          startReview = 1'b0;
    logic          stepNext = 1'b0;
    logic [AW-1:0] ramAddr;
    logic          ramRdEn;
    logic [27:0]   ramData = '0;
    logic [3:0]    displayTag;
    logic [1:0]    displayPill;
    logic [3:0]    displayId;
    logic [3:0]    displayMisses;
    logic          displayValid;
    logic          busy;
    logic          done;
`ifdef MISS_TOTAL_EN
    logic [7:0]    totalMisses;
`endif

    miss_record_reader #(
        .ADDR_W       (AW),
        .DWELL_CYCLES (D)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startReview   (startReview),
        .stepNext      (stepNext),
        .ramAddr       (ramAddr),
        .ramRdEn       (ramRdEn),
        .ramData       (ramData),
        .displayTag    (displayTag),
        .displayPill   (displayPill),
        .displayId     (displayId),
        .displayMisses (displayMisses),
        .displayValid  (displayValid),
        .busy          (busy),
        .done          (done)
`ifdef MISS_TOTAL_EN
        ,
        .totalMisses   (totalMisses)
`endif
    );

    always #5 clk = ~clk;

    logic [27:0] mem [NREC];
    int          read_cnt = 0;

    always @(posedge clk) begin
        if (ramRdEn) begin
            ramData  <= mem[ramAddr];
            read_cnt <= read_cnt + 1;
        end
    end

    entry_t exp_q[$];
    int     dur_q[$];
    int     checks = 0;
    int     errors = 0;
    int     entry_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected entry per displayed entry and checks its length when it ends.
    bit         active = 1'b0;
    int         run_len = 0;
    logic [1:0] cur_pill = '0;

    always @(negedge clk) begin
        if (!resetN) begin
            active = 1'b0;
        end else begin
            if (active && (!displayValid || (displayPill != cur_pill))) begin
                check("dur_available", 32'(dur_q.size() != 0), 1);
                if (dur_q.size() != 0) check("entry_len", 32'(run_len), 32'(dur_q.pop_front()));
                active = 1'b0;
            end
            if (displayValid && !active) begin
                check("exp_available", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    entry_t e;
                    e = exp_q.pop_front();
                    check("tag", 32'(displayTag), 32'(e.tag));
                    check("pill", 32'(displayPill), 32'(e.pill));
                    check("id", 32'(displayId), 32'(e.id));
                    check("misses", 32'(displayMisses), 32'(e.misses));
                end
                active   = 1'b1;
                run_len  = 1;
                cur_pill = displayPill;
                entry_cnt++;
            end else if (active) begin
                run_len++;
            end
        end
    end

    task automatic model_review(output int n_entries, output int n_reads, output int total);
        int sum;
        sum = 0;
        n_entries = 0;
        n_reads = 0;
        for (int a = 0; a < NREC; a++) begin
            n_reads++;
            if (mem[a][27:24] == 4'h0) break;
            for (int p = 0; p < 3; p++) begin
                entry_t e;
                e.tag    = mem[a][27:24];
                e.pill   = 2'(p);
                e.id     = 4'(mem[a] >> (20 - 8 * p));
                e.misses = 4'(mem[a] >> (16 - 8 * p));
                exp_q.push_back(e);
                n_entries++;
                sum += int'(e.misses);
            end
        end
        total = (sum > 255) ? 255 : sum;
    endtask

    task automatic fill_random(input int end_at);
        for (int a = 0; a < NREC; a++) begin
            mem[a] = {4'($urandom_range(1, 15)), 24'($urandom)};
        end
        if (end_at >= 0) mem[end_at][27:24] = 4'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ramAddr"}, 32'(ramAddr), 0);
        check({tag, "_ramRdEn"}, 32'(ramRdEn), 0);
        check({tag, "_dispTag"}, 32'(displayTag), 0);
        check({tag, "_dispPill"}, 32'(displayPill), 0);
        check({tag, "_dispId"}, 32'(displayId), 0);
        check({tag, "_dispMisses"}, 32'(displayMisses), 0);
        check({tag, "_dispValid"}, 32'(displayValid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
`ifdef MISS_TOTAL_EN
        check({tag, "_total"}, 32'(totalMisses), 0);
`endif
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        exp_q.delete();
        dur_q.delete();
    endtask

    // mode: 0 full dwell, 1 step one cycle in, 2 step on expiry cycle, 3 random
    task automatic run_review(input int mode, input bit check_latency, input bit poke_start,
                              input int abort_at);
        int n_entries, n_reads, total, rd0, seen, j, budget;
        model_review(n_entries, n_reads, total);
        rd0  = read_cnt;
        seen = entry_cnt;
        startReview = 1'b1;
        @(posedge clk);
        #1;
        startReview = 1'b0;
        @(negedge clk);
        #1;
        check("start_rden", 32'(ramRdEn), 1);
        check("start_addr", 32'(ramAddr), 0);
        check("start_busy", 32'(busy), 1);
`ifdef MISS_TOTAL_EN
        check("start_total_clear", 32'(totalMisses), 0);
`endif
        if (check_latency) begin
            @(negedge clk);
            #1;
            check("lat_n2_valid", 32'(displayValid), 0);
            check("lat_n2_rden", 32'(ramRdEn), 0);
            @(negedge clk);
            #1;
            check("lat_n3_valid", 32'(displayValid), 0);
            @(negedge clk);
            #1;
            check("lat_n4_valid", 32'(displayValid), 1);
        end
        for (int k = 0; k < n_entries; k++) begin
            budget = 2 * D + 20;
            while ((entry_cnt <= seen + k) && (budget > 0)) begin
                @(negedge clk);
                #1;
                budget--;
            end
            check("entry_arrived", 32'(entry_cnt > seen + k), 1);
            if (entry_cnt <= seen + k) break;
            if (k == abort_at) begin
                resetN = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                release_reset();
                return;
            end
            case (mode)
                0:       j = D;
                1:       j = 1;
                2:       j = D - 1;
                default: j = int'($urandom_range(0, D));
            endcase
            dur_q.push_back((j < D) ? j + 1 : D);
            if (poke_start && (k == 1)) begin
                startReview = 1'b1;
                @(posedge clk);
                #1;
                startReview = 1'b0;
            end else if (j < D) begin
                if (j > 0) repeat (j) @(negedge clk);
                stepNext = 1'b1;
                @(posedge clk);
                #1;
                stepNext = 1'b0;
            end
        end
        budget = 1000;
        while (!done && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
        #1;
        check("done", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_valid", 32'(displayValid), 0);
        check("done_rden", 32'(ramRdEn), 0);
        check("read_count", 32'(read_cnt - rd0), 32'(n_reads));
        check("entries_left", 32'(exp_q.size()), 0);
`ifdef MISS_TOTAL_EN
        check("total", 32'(totalMisses), 32'(total));
`endif
        exp_q.delete();
        dur_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        #1;
        check_reset_outputs("reset");
        release_reset();

        fill_random(-1);
        mem[0] = 28'h1_3_2_4_0_5_1;
        mem[1][27:24] = 4'h0;
        run_review(0, 1'b1, 1'b0, -1);

        fill_random(4);
        run_review(1, 1'b0, 1'b0, -1);
        run_review(2, 1'b0, 1'b0, -1);
        run_review(0, 1'b0, 1'b1, -1);

        fill_random(-1);
        for (int a = 0; a < NREC; a++) begin
            mem[a][19:16] = 4'hF;
            mem[a][11:8]  = 4'hF;
            mem[a][3:0]   = 4'hF;
        end
        run_review(1, 1'b0, 1'b0, -1);

        fill_random(-1);
        run_review(1, 1'b0, 1'b0, 9);
        @(negedge clk);
        check("post_rst_addr", 32'(ramAddr), 0);
        check("post_rst_busy", 32'(busy), 0);
        run_review(1, 1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            fill_random(($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NREC - 1)));
            run_review(3, 1'b0, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
